// File: rtl/lpc_periph_capture.sv
// LPC I/O / TPM peripheral target: decodes host cycles, answers SYNC/data on LAD and
// logs each completed hit cycle into a first-word fall-through capture FIFO.
module lpc_periph_capture #(
  parameter logic [15:0] ADDR_BASE   = 16'h0000,
  parameter logic [15:0] ADDR_MASK   = 16'hFFFF,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter bit          TPM_EN      = 1'b1
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        lframe_i,
  input  logic [3:0]  lad_i,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  input  logic [7:0]  din_i,
  output logic        rd_stb_o,
  output logic [15:0] addr_o,
  output logic [7:0]  wr_data_o,
  output logic        wr_stb_o,
  output logic [31:0] tdata_o,
  output logic        tvalid_o,
  input  logic        tready_i,
  output logic        fifo_full_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  WaitN = 4'(WAIT_CYCLES);

  typedef enum logic [3:0] {
    StIdle, StStart, StCycType, StAddr, StWdata, StTarH, StSync, StRdata, StTarP
  } state_e;

  // r_state names the bus phase of the clock just sampled; the drive registers
  // therefore always hold the value for the clock that follows it.
  state_e      r_state, w_state_d;
  logic [3:0]  r_cnt, w_cnt_d;
  logic [3:0]  r_start, w_start_d;
  logic        r_write, w_write_d;
  logic [15:0] r_addr, w_addr_d;
  logic [7:0]  r_data, w_data_d;
  logic        w_push;

  logic [3:0]  r_lad, w_lad_d;
  logic        r_lad_oe, w_lad_oe_d;
  logic        r_rd_stb, w_rd_stb_d;
  logic        r_wr_stb, w_wr_stb_d;
  logic        w_ready_next;
  logic [15:0] r_addr_out;
  logic [7:0]  r_wr_data_out;

  logic [31:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic [7:0]  r_drop;
  logic        w_full, w_empty, w_pop, w_push_ok, w_drop;
  logic [31:0] w_rec;

  logic w_start_ok, w_hit;

  assign w_start_ok = (lad_i == 4'h0) || (TPM_EN && (lad_i == 4'h5));
  assign w_hit      = ((r_addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_start_d = r_start;
    w_write_d = r_write;
    w_addr_d  = r_addr;
    w_data_d  = r_data;
    w_push    = 1'b0;
    if (!lframe_i) begin
      w_state_d = w_start_ok ? StStart : StIdle;
      if (w_start_ok) w_start_d = lad_i;
    end else begin
      unique case (r_state)
        StIdle: ;
        StStart: begin
          w_state_d = StIdle;
          if (lad_i == 4'h0 || lad_i == 4'h2) begin
            w_state_d = StCycType;
            w_write_d = lad_i[1];
          end
        end
        StCycType: begin
          w_state_d       = StAddr;
          w_cnt_d         = 4'd0;
          w_addr_d[15:12] = lad_i;
        end
        StAddr: begin
          w_cnt_d = r_cnt + 4'd1;
          unique case (r_cnt[1:0])
            2'd0: w_addr_d[11:8] = lad_i;
            2'd1: w_addr_d[7:4]  = lad_i;
            2'd2: w_addr_d[3:0]  = lad_i;
            default: begin
              w_cnt_d = 4'd0;
              if (r_write) begin
                w_state_d     = StWdata;
                w_data_d[3:0] = lad_i;
              end else begin
                w_state_d = StTarH;
              end
            end
          endcase
        end
        StWdata: begin
          if (r_cnt == 4'd0) begin
            w_cnt_d       = 4'd1;
            w_data_d[7:4] = lad_i;
          end else begin
            w_cnt_d   = 4'd0;
            w_state_d = StTarH;
          end
        end
        StTarH: begin
          if (r_cnt == 4'd0) begin
            w_cnt_d = 4'd1;
          end else begin
            w_cnt_d   = 4'd0;
            w_state_d = w_hit ? StSync : StIdle;
          end
        end
        StSync: begin
          if (r_cnt != WaitN) begin
            w_cnt_d = r_cnt + 4'd1;
          end else begin
            w_cnt_d   = 4'd0;
            w_state_d = r_write ? StTarP : StRdata;
          end
        end
        StRdata: begin
          if (r_cnt == 4'd0) begin
            w_cnt_d = 4'd1;
          end else begin
            w_cnt_d   = 4'd0;
            w_state_d = StTarP;
          end
        end
        StTarP: begin
          if (r_cnt == 4'd0) begin
            w_cnt_d = 4'd1;
            w_push  = 1'b1;
          end else begin
            w_cnt_d   = 4'd0;
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
      // The ready-SYNC clock has just been sampled: capture read data now.
      if (w_state_d == StSync && w_cnt_d == WaitN && !r_write) w_data_d = din_i;
    end
  end

  always_comb begin
    w_lad_d      = 4'h0;
    w_lad_oe_d   = 1'b0;
    w_rd_stb_d   = 1'b0;
    w_ready_next = 1'b0;
    unique case (w_state_d)
      StTarH: begin
        if (w_cnt_d == 4'd1 && w_hit) begin
          w_lad_oe_d   = 1'b1;
          w_ready_next = (WaitN == 4'd0);
          w_lad_d      = w_ready_next ? 4'h0 : 4'h6;
          w_rd_stb_d   = !r_write;
        end
      end
      StSync: begin
        w_lad_oe_d = 1'b1;
        if (w_cnt_d != WaitN) begin
          w_ready_next = ((w_cnt_d + 4'd1) == WaitN);
          w_lad_d      = w_ready_next ? 4'h0 : 4'h6;
        end else begin
          w_lad_d = r_write ? 4'hF : din_i[3:0];
        end
      end
      StRdata: begin
        w_lad_oe_d = 1'b1;
        w_lad_d    = (w_cnt_d == 4'd0) ? r_data[7:4] : 4'hF;
      end
      default: ;
    endcase
    w_wr_stb_d = w_ready_next && r_write;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state       <= StIdle;
      r_cnt         <= 4'd0;
      r_start       <= 4'h0;
      r_write       <= 1'b0;
      r_addr        <= 16'h0000;
      r_data        <= 8'h00;
      r_lad         <= 4'h0;
      r_lad_oe      <= 1'b0;
      r_rd_stb      <= 1'b0;
      r_wr_stb      <= 1'b0;
      r_addr_out    <= 16'h0000;
      r_wr_data_out <= 8'h00;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_start  <= w_start_d;
      r_write  <= w_write_d;
      r_addr   <= w_addr_d;
      r_data   <= w_data_d;
      r_lad    <= w_lad_d;
      r_lad_oe <= w_lad_oe_d;
      r_rd_stb <= w_rd_stb_d;
      r_wr_stb <= w_wr_stb_d;
      if (w_ready_next) begin
        r_addr_out <= r_addr;
        if (r_write) r_wr_data_out <= r_data;
      end
    end
  end

  // Capture FIFO: extra pointer MSB distinguishes full from empty.
  assign w_rec     = {r_start, r_addr, r_data, 2'b00, (r_write ? 2'b01 : 2'b11)};
  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && tready_i;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= w_rec;
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_drop <= 8'h00;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign lad_o       = r_lad;
  assign lad_oe_o    = r_lad_oe;
  assign rd_stb_o    = r_rd_stb;
  assign wr_stb_o    = r_wr_stb;
  assign addr_o      = r_addr_out;
  assign wr_data_o   = r_wr_data_out;
  assign tdata_o     = r_mem[r_rptr[AW-1:0]];
  assign tvalid_o    = !w_empty;
  assign fifo_full_o = w_full;
  assign drop_cnt_o  = r_drop;

endmodule

// File: tb/tb_lpc_periph_capture.sv
// Bench for lpc_periph_capture: two targets on one LPC bus (A: I/O 0x008x, no wait;
// B: 0x0Fxx, two long-wait SYNCs) driven by a vector table plus corner-case sequences.
module tb_lpc_periph_capture;

  logic       clk = 1'b0;
  logic       nrst;
  logic       lframe;
  logic [3:0] lad;
  logic [7:0] din;
  logic       tready_a, tready_b;

  logic [3:0]  a_lad, b_lad;
  logic        a_oe, b_oe, a_rs, b_rs, a_ws, b_ws;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata, a_drop, b_drop;
  logic [31:0] a_tdata, b_tdata;
  logic        a_tvalid, b_tvalid, a_full, b_full;

  int total, bad, a_oe_seen;

  always #5 clk = ~clk;

  lpc_periph_capture #(
    .ADDR_BASE(16'h0080), .ADDR_MASK(16'hFFF0), .WAIT_CYCLES(0), .FIFO_DEPTH(4), .TPM_EN(1'b1)
  ) u_a (
    .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad), .lad_o(a_lad),
    .lad_oe_o(a_oe), .din_i(din), .rd_stb_o(a_rs), .addr_o(a_addr), .wr_data_o(a_wdata),
    .wr_stb_o(a_ws), .tdata_o(a_tdata), .tvalid_o(a_tvalid), .tready_i(tready_a),
    .fifo_full_o(a_full), .drop_cnt_o(a_drop)
  );

  lpc_periph_capture #(
    .ADDR_BASE(16'h0F00), .ADDR_MASK(16'hFF00), .WAIT_CYCLES(2), .FIFO_DEPTH(4), .TPM_EN(1'b1)
  ) u_b (
    .clk_i(clk), .nrst_i(nrst), .lframe_i(lframe), .lad_i(lad), .lad_o(b_lad),
    .lad_oe_o(b_oe), .din_i(din), .rd_stb_o(b_rs), .addr_o(b_addr), .wr_data_o(b_wdata),
    .wr_stb_o(b_ws), .tdata_o(b_tdata), .tvalid_o(b_tvalid), .tready_i(tready_b),
    .fifo_full_o(b_full), .drop_cnt_o(b_drop)
  );

  // One bus clock: host inputs, then the target drive expected in the following clock.
  typedef struct packed {
    logic       lf;
    logic [3:0] lad;
    logic       a_oe;
    logic [3:0] a_lad;
    logic       a_ws;
    logic       b_oe;
    logic [3:0] b_lad;
    logic       b_rs;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic lf, input logic [3:0] l, input logic aoe, input logic [3:0] al,
                     input logic aws, input logic boe, input logic [3:0] bl, input logic brs);
    vq.push_back('{lf, l, aoe, al, aws, boe, bl, brs});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic lf, input logic [3:0] l);
    lframe = lf;
    lad    = l;
    @(posedge clk);
    #1;
    if (a_oe) a_oe_seen++;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    vec_t v;
    for (int i = lo; i < hi; i++) begin
      v = vq[i];
      cyc(v.lf, v.lad);
      chk($sformatf("vec%0d a_oe", i), 32'(a_oe), 32'(v.a_oe));
      chk($sformatf("vec%0d b_oe", i), 32'(b_oe), 32'(v.b_oe));
      chk($sformatf("vec%0d a_wr_stb", i), 32'(a_ws), 32'(v.a_ws));
      chk($sformatf("vec%0d b_rd_stb", i), 32'(b_rs), 32'(v.b_rs));
      if (v.a_oe) chk($sformatf("vec%0d a_lad", i), 32'(a_lad), 32'(v.a_lad));
      if (v.b_oe) chk($sformatf("vec%0d b_lad", i), 32'(b_lad), 32'(v.b_lad));
    end
  endtask

  task automatic bus_write(input bit do_start, input logic [3:0] st, input logic [15:0] adr,
                           input logic [7:0] dat);
    if (do_start) cyc(1'b0, st);
    cyc(1'b1, 4'h2);
    cyc(1'b1, adr[15:12]);
    cyc(1'b1, adr[11:8]);
    cyc(1'b1, adr[7:4]);
    cyc(1'b1, adr[3:0]);
    cyc(1'b1, dat[3:0]);
    cyc(1'b1, dat[7:4]);
    repeat (9) cyc(1'b1, 4'hF);
  endtask

  task automatic pop_a();
    tready_a = 1'b1;
    cyc(1'b1, 4'hF);
    tready_a = 1'b0;
  endtask

  task automatic pop_b();
    tready_b = 1'b1;
    cyc(1'b1, 4'hF);
    tready_b = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; a_oe_seen = 0;
    nrst = 1'b0; lframe = 1'b1; lad = 4'hF; din = 8'h3C;
    tready_a = 1'b0; tready_b = 1'b0;

    // I/O write 0x0080 <- 0xA5 (A hits, WAIT 0; B misses)
    add(0, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h2, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h8, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h5, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hA, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 1, 4'h0, 1, 0, 4'h0, 0);
    add(1, 4'hF, 1, 4'hF, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    // TPM read 0x0F00, din 0x3C (B hits, WAIT 2): LAD 6,6,0,C,3,F
    add(0, 4'h5, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'h0, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 1, 4'h6, 1);
    add(1, 4'hF, 0, 4'h0, 0, 1, 4'h6, 0);
    add(1, 4'hF, 0, 4'h0, 0, 1, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 1, 4'hC, 0);
    add(1, 4'hF, 0, 4'h0, 0, 1, 4'h3, 0);
    add(1, 4'hF, 0, 4'h0, 0, 1, 4'hF, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);
    add(1, 4'hF, 0, 4'h0, 0, 0, 4'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst a_oe", 32'(a_oe), 32'd0);
    chk("rst a_lad", 32'(a_lad), 32'd0);
    chk("rst a_tvalid", 32'(a_tvalid), 32'd0);
    chk("rst a_full", 32'(a_full), 32'd0);
    chk("rst a_drop", 32'(a_drop), 32'd0);
    chk("rst a_addr", 32'(a_addr), 32'd0);
    chk("rst b_oe", 32'(b_oe), 32'd0);
    chk("rst b_tvalid", 32'(b_tvalid), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hF);

    run_vecs(0, 14);
    chk("wr a_tvalid", 32'(a_tvalid), 32'd1);
    chk("wr a_tdata", a_tdata, 32'h00080A51);
    chk("wr a_addr", 32'(a_addr), 32'h0080);
    chk("wr a_wdata", 32'(a_wdata), 32'hA5);
    chk("wr b_tvalid", 32'(b_tvalid), 32'd0);
    pop_a();
    chk("wr pop a_tvalid", 32'(a_tvalid), 32'd0);

    run_vecs(14, 30);
    chk("rd b_tvalid", 32'(b_tvalid), 32'd1);
    chk("rd b_tdata", b_tdata, 32'h50F003C3);
    chk("rd b_addr", 32'(b_addr), 32'h0F00);
    chk("rd a_tvalid", 32'(a_tvalid), 32'd0);
    pop_b();
    chk("rd pop b_tvalid", 32'(b_tvalid), 32'd0);

    // masked miss: 0x0090 & 0xFFF0 != 0x0080
    a_oe_seen = 0;
    bus_write(1'b1, 4'h0, 16'h0090, 8'h11);
    chk("miss a_oe_seen", 32'(a_oe_seen), 32'd0);
    chk("miss a_tvalid", 32'(a_tvalid), 32'd0);

    // six hits into a 4-deep FIFO with no consumer
    for (int i = 1; i <= 6; i++) bus_write(1'b1, 4'h0, 16'h0080, 8'(i));
    chk("fifo full", 32'(a_full), 32'd1);
    chk("fifo drop", 32'(a_drop), 32'd2);
    chk("fifo head", a_tdata, 32'h00080011);
    pop_a();
    chk("fifo head2", a_tdata, 32'h00080021);
    chk("fifo notfull", 32'(a_full), 32'd0);

    // new START mid-SYNC aborts B's read; B then resumes from START
    cyc(1'b0, 4'h5);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'hF);
    cyc(1'b1, 4'hF);
    chk("abort b_oe before", 32'(b_oe), 32'd1);
    cyc(1'b0, 4'h5);
    chk("abort b_oe after", 32'(b_oe), 32'd0);
    chk("abort b_tvalid", 32'(b_tvalid), 32'd0);
    bus_write(1'b0, 4'h5, 16'h0F00, 8'h77);
    chk("abort resume b_tvalid", 32'(b_tvalid), 32'd1);
    chk("abort resume b_tdata", b_tdata, 32'h50F00771);

    // asynchronous reset in the middle of the address phase
    cyc(1'b0, 4'h0);
    cyc(1'b1, 4'h2);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h0);
    #3 nrst = 1'b0;
    #1;
    chk("arst a_tvalid", 32'(a_tvalid), 32'd0);
    chk("arst a_drop", 32'(a_drop), 32'd0);
    chk("arst a_addr", 32'(a_addr), 32'd0);
    chk("arst a_wdata", 32'(a_wdata), 32'd0);
    chk("arst a_oe", 32'(a_oe), 32'd0);
    chk("arst b_tvalid", 32'(b_tvalid), 32'd0);
    chk("arst b_addr", 32'(b_addr), 32'd0);
    #2 nrst = 1'b1;
    @(posedge clk);
    #1;
    a_oe_seen = 0;
    cyc(1'b1, 4'h8);
    cyc(1'b1, 4'h0);
    cyc(1'b1, 4'h3);
    cyc(1'b1, 4'h3);
    repeat (9) cyc(1'b1, 4'hF);
    chk("arst no drive", 32'(a_oe_seen), 32'd0);
    chk("arst no push", 32'(a_tvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lpc_periph_capture.md
LPC_PERIPH_CAPTURE -- requirements
Module: lpc_periph_capture

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 16'h0000: I/O address decode base.
REQ-002 SHALL have parameter ADDR_MASK, default 16'hFFFF: bits of address compared against ADDR_BASE.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, range 0..15: long-wait SYNC (0x6) clocks before ready SYNC.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, power of two >= 2: capture FIFO entries.
REQ-005 SHALL have parameter TPM_EN, default 1: 1 accepts START 0x5 (TPM) as well as 0x0 (I/O).
REQ-006 SHALL have port clk_i  in  1  LPC clock; single clock domain.
REQ-007 SHALL have port nrst_i  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port lframe_i  in  1  LPC frame, active-low.
REQ-009 SHALL have port lad_i  in  4  LAD bus input; lad_o  out  4  LAD drive value; lad_oe_o  out  1  LAD output enable.
REQ-010 SHALL have port din_i  in  8  read data from register bank; rd_stb_o  out  1  read-hit strobe.
REQ-011 SHALL have port addr_o  out  16  last decoded address; wr_data_o  out  8  last write data; wr_stb_o  out  1  write-hit strobe.
REQ-012 SHALL have port tdata_o  out  32  FIFO head record; tvalid_o  out  1  FIFO non-empty; tready_i  in  1  consumer pop.
REQ-013 SHALL have port fifo_full_o  out  1  FIFO full; drop_cnt_o  out  8  dropped-record count.

Function
REQ-014 SHALL implement states IDLE, START, CYCTYPE, ADDR, WDATA, TAR_H, SYNC, RDATA, TAR_P; all outputs registered.
REQ-015 SHALL enter START from any state when lframe_i=0 and lad_i=0x0, or lad_i=0x5 with TPM_EN=1; lframe_i=0 with other nibble -> IDLE; no FIFO push for the interrupted cycle.
REQ-016 SHALL latch start nibble each clock lframe_i=0 in START (last wins); first clock lframe_i=1 is CYCTYPE.
REQ-017 SHALL treat CYCTYPE 0x0 as read, 0x2 as write; any other nibble -> IDLE, LAD never driven.
REQ-018 SHALL capture 4 address nibbles MSB first (ADDR, 4 clocks); write then captures 2 data nibbles low first (WDATA, 2 clocks).
REQ-019 SHALL spend 2 clocks in TAR_H without driving; hit = ((addr & ADDR_MASK) == (ADDR_BASE & ADDR_MASK)); miss -> IDLE, no drive, no push, no strobes.
REQ-020 SHALL on hit drive SYNC: lad_o=0x6 for WAIT_CYCLES clocks then 0x0 for 1 clock, lad_oe_o=1.
REQ-021 SHALL on read hit pulse rd_stb_o in first SYNC clock, sample din_i at end of ready-SYNC clock, then drive din[3:0], din[7:4] (RDATA, 2 clocks).
REQ-022 SHALL on write hit update addr_o/wr_data_o and pulse wr_stb_o 1 clock in the ready-SYNC clock; read hit updates addr_o only.
REQ-023 SHALL in TAR_P drive 0xF first clock, lad_oe_o=0 second clock, then IDLE.
REQ-024 SHALL push one record at completion of TAR_P: [31:28] start nibble, [27:12] address, [11:4] data (write data or sampled din_i), [3:2]=00, [1:0]=01 write / 11 read.
REQ-025 SHALL present FIFO head combinationally on tdata_o (first-word fall-through); pop on tvalid_o & tready_i.
REQ-026 SHALL, on push when full without same-clock pop, drop record and increment drop_cnt_o saturating at 255; push+pop when full succeeds, no drop.
REQ-027 SHALL push+pop when empty: record stored, tvalid_o=1 next clock; pointers wrap modulo FIFO_DEPTH.
REQ-028 SHALL deassert lad_oe_o from the clock after lframe_i=0 is sampled mid-cycle.

Reset
REQ-029 SHALL on nrst_i=0 asynchronously: state IDLE, lad_oe_o=0, lad_o=0, rd_stb_o=wr_stb_o=0, addr_o=0, wr_data_o=0, FIFO empty, tvalid_o=0, fifo_full_o=0, drop_cnt_o=0.
REQ-030 SHALL abandon any in-progress cycle on reset with no push; first cycle after release needs fresh START.

Verification
REQ-031 SHALL cover I/O write 0x0080 data 0xA5, WAIT_CYCLES=0 -> SYNC 0x0 one clock, wr_stb_o pulse, tdata_o=0x0_0080_A5_1 -> 32'h00080A51.
REQ-032 SHALL cover TPM read 0x0F00, din_i=0x3C, WAIT_CYCLES=2 -> LAD 6,6,0,C,3,F then release; tdata_o=32'h50F003C3.
REQ-033 SHALL cover miss (ADDR_MASK=16'hFFF0, ADDR_BASE=16'h0080, addr 0x0090) -> lad_oe_o never 1, no push.
REQ-034 SHALL cover FIFO_DEPTH=4, tready_i=0, 6 write hits -> fifo_full_o=1, drop_cnt_o=2, head = first record.
REQ-035 SHALL cover lframe_i low with 0x5 during SYNC -> lad_oe_o=0 next clock, state START, no push; and nrst_i low mid-ADDR -> all outputs reset values immediately.
